twofish_subkey_store: RTL and testbench
=======================================

# twofish_subkey_store

Sequencer and storage for the Twofish expanded round subkeys. It sits directly downstream of the combinational H-function stage. On accepting a 128-bit key it holds that key on the H-function key input and steps the pair index i from 0 to 19. Each cycle it captures the returned (K0, K1) pair into a 40-entry × 32-bit subkey RAM, which the round datapath reads through a registered read port.

## Interface
- Parameters: none. Fixed at 40 subkeys, 20 pairs, 32-bit words.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  128  user key, packed {M0,M1,M2,M3} with M0 in bits [127:96].
- key_valid  in  1  key_in is valid this cycle.
- key_ready  out  1  block will accept a key this cycle.
- h_key  out  128  registered copy of the accepted key, driven to the H-function key input.
- h_i  out  6  pair index driven to the H-function i input, range 0..19.
- h_k0  in  32  even subkey K[2i] from the H-function, combinational in the same cycle.
- h_k1  in  32  odd subkey K[2i+1] from the H-function, combinational in the same cycle.
- rd_addr  in  6  subkey read address, 0..39.
- rd_data  out  32  subkey read data, one-cycle latency.
- keys_valid  out  1  all 40 subkeys for the current key are stored.
- done  out  1  one-cycle pulse when generation completes.

## Operation
- States: IDLE, GEN, READY.
- IDLE: key_ready=1, keys_valid=0. If key_valid, latch key_in into h_key, clear cnt to 0, go to GEN.
- GEN: key_ready=0; key_valid is ignored. h_i=cnt.
  - Each edge writes h_k0 to slot 2·cnt and h_k1 to slot 2·cnt+1, then increments cnt.
  - The edge on which cnt=19 writes slots 38 and 39, goes to READY, sets keys_valid=1 and pulses done=1.
- READY: key_ready=1, keys_valid=1.
  - If key_valid: latch the new key, clear keys_valid on the same edge, cnt=0, go to GEN. Rekeying always regenerates all 40 slots.
- h_i: equals cnt in GEN, held at 0 in IDLE and READY. h_key holds its last latched value outside GEN.
- cnt: 5-bit counter, 0..19; never wraps past 19. h_i = {1'b0, cnt}.
- Slot address arithmetic: 2·cnt is {cnt,1'b0} and 2·cnt+1 is {cnt,1'b1}. Both are 6-bit.
- Read port:
  - rd_data is registered from rd_addr on every edge, in any state.
  - rd_addr in 40..63 returns 32'h0.
  - Reads during GEN return the current RAM contents (a mix of old and new). Consumers qualify reads with keys_valid.
- rst:
  - Forces IDLE, cnt=0, keys_valid=0, done=0, h_key=0, rd_data=0.
  - RAM contents are not cleared.
  - rst during GEN aborts generation; the partial results are not flagged valid.

## Timing
- Reset values: key_ready=1, keys_valid=0, done=0, h_i=0, h_key=0, rd_data=0.
- Acceptance edge E0 is the edge with key_valid & key_ready.
- Edges E1..E20 write pairs 0..19 respectively.
- keys_valid and done are high in the cycle after E20. done falls after one cycle.
- Latency from the acceptance edge to keys_valid is 20 cycles.
- key_ready is low in the 20 cycles between E0 and E20 and high again in the cycle after E20. A back-to-back rekey is accepted at E21 at the earliest.
- Read latency: rd_addr sampled at edge N gives rd_data valid after edge N.
- A write and a read of the same slot on one edge return the old data (read-before-write).

## Test plan
Bench H-function stub: h_k0 = 32'hA000_0000 | h_i, h_k1 = 32'hB000_0000 | h_i.
- Reset, then idle for 5 cycles -> key_ready=1, keys_valid=0, done=0, h_i=0, rd_data=0.
- Present key_in=128'h00112233_44556677_8899AABB_CCDDEEFF with key_valid=1 for one cycle -> h_key holds that value; h_i steps 0..19 over 20 cycles; keys_valid and a single done pulse appear exactly 20 cycles after acceptance.
- After completion, read all 40 addresses -> slot 2n=32'hA000_0000+n and slot 2n+1=32'hB000_0000+n, for n=0..19. rd_addr=40 and rd_addr=63 return 0.
- Hold key_valid=1 throughout GEN with a different key -> that key is ignored and h_key is unchanged. The held key is accepted at the first READY cycle; keys_valid drops on that edge and regeneration follows.
- Assert rst when h_i=7 -> next cycle IDLE, keys_valid=0, h_i=0, no done pulse. A new key then completes normally in 20 cycles.
- Read slot 14 on the same edge its GEN write occurs (h_i=7) -> the old value is returned; reading the next cycle returns 32'hA000_0007.

Source files
------------

// File: rtl/twofish_subkey_store_if.sv
// Bus between the Twofish subkey store, its key source, the H-function stage
// and the round-datapath read port.
interface twofish_subkey_store_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] h_key;
    logic [5:0]   h_i;
    logic [31:0]  h_k0;
    logic [31:0]  h_k1;
    logic [5:0]   rd_addr;
    logic [31:0]  rd_data;
    logic         keys_valid;
    logic         done;

    modport slave (
        input  key_in, key_valid, h_k0, h_k1, rd_addr,
        output key_ready, h_key, h_i, rd_data, keys_valid, done
    );

    modport master (
        output key_in, key_valid, h_k0, h_k1, rd_addr,
        input  key_ready, h_key, h_i, rd_data, keys_valid, done
    );
endinterface

// File: rtl/twofish_subkey_store.sv
// Twofish round-subkey sequencer: drives pair index 0..19 into the H-function
// and stores the returned (K[2i], K[2i+1]) pairs for registered readback.
module twofish_subkey_store (
    input  logic                   clk,
    input  logic                   rst,
    twofish_subkey_store_if.slave  bus
);
    localparam int unsigned NUM_PAIRS = 20;
    localparam logic [4:0]  LAST_PAIR = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e       state_q;
    logic [4:0]   cnt_q;
    logic         key_ready_q;
    logic         keys_valid_q;
    logic         done_q;
    logic [127:0] h_key_q;
    logic [31:0]  rd_data_q;

    // Even slots (K[2i]) and odd slots (K[2i+1]) live in separate banks so each
    // bank sees a single write per cycle; slot address = {pair, odd}.
    logic [31:0]  ram_even_q [0:NUM_PAIRS-1];
    logic [31:0]  ram_odd_q  [0:NUM_PAIRS-1];

    logic         wr_en_s;
    logic [4:0]   rd_pair_s;
    logic         rd_in_range_s;

    assign wr_en_s       = (state_q == ST_GEN);
    assign rd_pair_s     = bus.rd_addr[5:1];
    assign rd_in_range_s = (rd_pair_s <= LAST_PAIR);

    // Control FSM: key acceptance, pair stepping and completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 5'd0;
            key_ready_q  <= 1'b1;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
            h_key_q      <= 128'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (bus.key_valid) begin
                        h_key_q      <= bus.key_in;
                        cnt_q        <= 5'd0;
                        keys_valid_q <= 1'b0;
                        key_ready_q  <= 1'b0;
                        state_q      <= ST_GEN;
                    end else begin
                        cnt_q <= 5'd0;
                    end
                end
                ST_GEN: begin
                    if (cnt_q == LAST_PAIR) begin
                        // cnt returns to 0 so h_i reads 0 while READY
                        cnt_q        <= 5'd0;
                        keys_valid_q <= 1'b1;
                        done_q       <= 1'b1;
                        key_ready_q  <= 1'b1;
                        state_q      <= ST_READY;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    cnt_q        <= 5'd0;
                    key_ready_q  <= 1'b1;
                    keys_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Subkey capture; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram_even_q[cnt_q] <= bus.h_k0;
            ram_odd_q[cnt_q]  <= bus.h_k1;
        end
    end

    // Registered read port; nonblocking write above makes same-edge reads see old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 32'h0;
        end else if (rd_in_range_s) begin
            rd_data_q <= bus.rd_addr[0] ? ram_odd_q[rd_pair_s] : ram_even_q[rd_pair_s];
        end else begin
            rd_data_q <= 32'h0;
        end
    end

    assign bus.key_ready  = key_ready_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.done       = done_q;
    assign bus.h_key      = h_key_q;
    assign bus.h_i        = {1'b0, cnt_q};
    assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_twofish_subkey_store.sv
// Directed self-checking bench for twofish_subkey_store with an H-function stub.
module tb_twofish_subkey_store;
    logic clk;
    logic rst;
    logic stub_alt;
    int   n_cmp;
    int   n_err;

    localparam logic [127:0] KEY_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] KEY_B = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] KEY_C = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    twofish_subkey_store_if bus_if ();

    twofish_subkey_store dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // H-function stub; the alternate bases let one generation leave distinct old data
    assign bus_if.h_k0 = (stub_alt ? 32'hC000_0000 : 32'hA000_0000) | {26'd0, bus_if.h_i};
    assign bus_if.h_k1 = (stub_alt ? 32'hD000_0000 : 32'hB000_0000) | {26'd0, bus_if.h_i};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_flags(input string tag, input logic kv, input logic dn, input logic kr);
        check({tag, ".keys_valid"}, {127'd0, bus_if.keys_valid}, {127'd0, kv});
        check({tag, ".done"},       {127'd0, bus_if.done},       {127'd0, dn});
        check({tag, ".key_ready"},  {127'd0, bus_if.key_ready},  {127'd0, kr});
    endtask

    initial begin
        logic [31:0] exp_word;
        n_cmp = 0;
        n_err = 0;
        stub_alt = 1'b0;
        rst = 1'b1;
        bus_if.key_in    = 128'd0;
        bus_if.key_valid = 1'b0;
        bus_if.rd_addr   = 6'd0;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) tick();

        // reset / idle state
        check_idle_flags("reset", 1'b0, 1'b0, 1'b1);
        check("reset.h_i", {122'd0, bus_if.h_i}, 128'd0);
        check("reset.h_key", bus_if.h_key, 128'd0);
        check("reset.rd_data", {96'd0, bus_if.rd_data}, 128'd0);

        // first key: single-cycle valid, then 20 pairs
        bus_if.key_in    = KEY_A;
        bus_if.key_valid = 1'b1;
        tick();
        bus_if.key_valid = 1'b0;
        bus_if.key_in    = 128'd0;
        check("gen1.h_key", bus_if.h_key, KEY_A);
        for (int n = 0; n < 20; n++) begin
            check("gen1.h_i", {122'd0, bus_if.h_i}, n);
            check_idle_flags("gen1", 1'b0, 1'b0, 1'b0);
            tick();
        end
        check_idle_flags("gen1.end", 1'b1, 1'b1, 1'b1);
        check("gen1.end.h_i", {122'd0, bus_if.h_i}, 128'd0);
        check("gen1.end.h_key", bus_if.h_key, KEY_A);
        tick();
        check_idle_flags("gen1.after", 1'b1, 1'b0, 1'b1);

        // full readback plus out-of-range addresses
        for (int a = 0; a < 40; a++) begin
            bus_if.rd_addr = a[5:0];
            tick();
            exp_word = ((a % 2) == 0) ? (32'hA000_0000 + 32'(a / 2)) : (32'hB000_0000 + 32'(a / 2));
            check("read.slot", {96'd0, bus_if.rd_data}, {96'd0, exp_word});
        end
        bus_if.rd_addr = 6'd40;
        tick();
        check("read.addr40", {96'd0, bus_if.rd_data}, 128'd0);
        bus_if.rd_addr = 6'd63;
        tick();
        check("read.addr63", {96'd0, bus_if.rd_data}, 128'd0);

        // rekey with KEY_B, then hold key_valid with KEY_C across GEN
        bus_if.key_in    = KEY_B;
        bus_if.key_valid = 1'b1;
        tick();
        bus_if.key_in = KEY_C;
        for (int n = 0; n < 20; n++) begin
            check("hold.h_key", bus_if.h_key, KEY_B);
            check_idle_flags("hold", 1'b0, 1'b0, 1'b0);
            tick();
        end
        check_idle_flags("hold.ready", 1'b1, 1'b1, 1'b1);
        check("hold.ready.h_key", bus_if.h_key, KEY_B);
        tick();
        bus_if.key_valid = 1'b0;
        check_idle_flags("hold.reaccept", 1'b0, 1'b0, 1'b0);
        check("hold.reaccept.h_key", bus_if.h_key, KEY_C);
        check("hold.reaccept.h_i", {122'd0, bus_if.h_i}, 128'd0);
        for (int n = 0; n < 20; n++) tick();
        check_idle_flags("hold.regen", 1'b1, 1'b1, 1'b1);

        // fill with alternate values so old vs new data is distinguishable
        stub_alt = 1'b1;
        bus_if.key_in    = KEY_A;
        bus_if.key_valid = 1'b1;
        tick();
        bus_if.key_valid = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        check_idle_flags("alt", 1'b1, 1'b1, 1'b1);
        bus_if.rd_addr = 6'd14;
        tick();
        check("alt.slot14", {96'd0, bus_if.rd_data}, {96'd0, 32'hC000_0007});
        stub_alt = 1'b0;

        // read slot 14 on the edge that rewrites it
        bus_if.key_in    = KEY_B;
        bus_if.key_valid = 1'b1;
        tick();
        bus_if.key_valid = 1'b0;
        for (int n = 0; n < 7; n++) tick();
        check("rbw.h_i", {122'd0, bus_if.h_i}, 128'd7);
        bus_if.rd_addr = 6'd14;
        tick();
        check("rbw.old", {96'd0, bus_if.rd_data}, {96'd0, 32'hC000_0007});
        tick();
        check("rbw.new", {96'd0, bus_if.rd_data}, {96'd0, 32'hA000_0007});
        for (int n = 0; n < 11; n++) tick();
        check_idle_flags("rbw.end", 1'b1, 1'b1, 1'b1);

        // reset in the middle of generation
        bus_if.key_in    = KEY_C;
        bus_if.key_valid = 1'b1;
        tick();
        bus_if.key_valid = 1'b0;
        for (int n = 0; n < 7; n++) tick();
        check("abort.h_i_before", {122'd0, bus_if.h_i}, 128'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_flags("abort", 1'b0, 1'b0, 1'b1);
        check("abort.h_i", {122'd0, bus_if.h_i}, 128'd0);
        check("abort.h_key", bus_if.h_key, 128'd0);
        check("abort.rd_data", {96'd0, bus_if.rd_data}, 128'd0);
        for (int n = 0; n < 25; n++) begin
            tick();
            check_idle_flags("abort.quiet", 1'b0, 1'b0, 1'b1);
        end

        // fresh key after abort completes in exactly 20 cycles
        bus_if.key_in    = KEY_A;
        bus_if.key_valid = 1'b1;
        tick();
        bus_if.key_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            check("post.h_i", {122'd0, bus_if.h_i}, n);
            check_idle_flags("post", 1'b0, 1'b0, 1'b0);
            tick();
        end
        check_idle_flags("post.end", 1'b1, 1'b1, 1'b1);
        bus_if.rd_addr = 6'd39;
        tick();
        check("post.slot39", {96'd0, bus_if.rd_data}, {96'd0, 32'hB000_0013});
        check("post.done_fell", {127'd0, bus_if.done}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
